booth_seq_multiplier: RTL and testbench
=======================================

Name: booth_seq_multiplier

Overview:
- Iterative signed two's-complement multiplier using radix-2 Booth recoding.
- Takes two WIDTH-bit signed operands on a start pulse and produces a 2*WIDTH-bit signed product after WIDTH iteration cycles.
- Signals completion with a one-cycle done pulse.
- Serves as the area-lean alternative to a single-cycle combinational multiplier; both must produce bit-identical results.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled at rising clk edge while IDLE
- multiplicand  input  WIDTH  signed operand A
- multiplier  input  WIDTH  signed operand B
- product  output  2*WIDTH  signed result A*B, registered
- done  output  1  one-cycle completion pulse, registered

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- Reset (async assert, any state): state=IDLE, product=0, done=0, all internal registers=0. Mid-operation reset aborts with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge latches multiplicand into M (sign-extended to WIDTH+1 bits).
  - Same edge loads the Booth register {ACC=0 (WIDTH+1 bits), Q=multiplier, q_-1=0} and count=0.
  - Transition to RUN.
- RUN, one Booth step per cycle:
  - Examine {Q[0], q_-1}: 01 → ACC+=M; 10 → ACC-=M; 00/11 → no op.
  - Then arithmetic right shift of {ACC,Q,q_-1} by 1, preserving the sign of ACC.
  - count increments; after WIDTH steps, transition to DONE.
- ACC is WIDTH+1 bits so -(-2^(WIDTH-1)) does not overflow. Final product = {ACC[WIDTH-1:0], Q}.
- DONE:
  - product register updated and done=1 for exactly one cycle.
  - Next edge: done=0, back to IDLE.
- Latency: start sampled at edge k → done high after edge k+WIDTH+1. Nominal: 33 cycles after start for WIDTH=32.
- product holds its last value until the next completed operation. It is not cleared on start and not updated during RUN.
- start while in RUN or DONE is ignored and not queued. Operands are only sampled at the accepting edge; later input changes have no effect.
- start held high continuously: a new operation is accepted on the first IDLE edge after DONE.
- Result is exact for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2), and zero/one operands.
- No overflow or saturation; product is always the full-precision result.

Decomposition:
- Package booth_mult_pkg: WIDTH default constant and state enum (IDLE, RUN, DONE).
- One natural sub-module, booth_step (combinational):
  - inputs: ACC, Q, q_-1, M
  - outputs: next ACC, Q, q_-1 after add/sub and arithmetic shift.
- Top module holds the FSM, counter and output registers.
- Companion combinational signed multiplier (A*B, 2*WIDTH-bit result, zero latency) is a separate block and serves as the bench's golden model.

Test Plan:
- Apply rst for one cycle, then release → product=0, done=0. Reset asserted mid-RUN → no done pulse; product stays 0.
- Sign combinations → product matches the combinational model on the done pulse:
  - 5 * -3 → -15
  - 4 * 7 → 28
  - -6 * -4 → 24
  - -8 * 5 → -40
- 123 * 0 → 0; 456 * 1 → 456; 65536 * 65536 → 64'h0000_0001_0000_0000.
- -2147483648 * -2147483648 → 64'h4000_0000_0000_0000. Also -2147483648 * 1 → 64'hFFFF_FFFF_8000_0000.
- Timing: start pulsed at edge k → done high only in the cycle after edge k+33, exactly one cycle wide. A second start pulsed during RUN is ignored; product holds until the next done.
- Randomized: 1000 operand pairs with back-to-back starts → every result equals the golden model; no missed or extra done pulses.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// Shared constants and FSM state encoding for the sequential radix-2 Booth multiplier.
package booth_mult_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into ACC, then an
// arithmetic right shift of the combined {ACC, Q, q_-1} register.
module booth_step
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    unique case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // ACC's sign bit is replicated; its LSB falls into the top of Q.
  assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next[WIDTH-1] = sum[0];
  assign q_m1_next = q[0];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_q_shift
      assign q_next[gi] = q[gi+1];
    end
  endgenerate

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative signed multiplier: one Booth step per cycle, WIDTH steps per operation,
// full-precision 2*WIDTH-bit product with a one-cycle done pulse.
module booth_seq_multiplier
  import booth_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_reg;
  logic [WIDTH:0]     m_reg;
  logic [WIDTH:0]     acc_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_m1_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic               done_reg;

  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   q_next;
  logic               q_m1_next;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc       (acc_reg),
    .q         (q_reg),
    .q_m1      (q_m1_reg),
    .m         (m_reg),
    .acc_next  (acc_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      m_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      q_m1_reg    <= 1'b0;
      count_reg   <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // M carries an extra sign bit so subtracting the most negative value cannot overflow.
            m_reg     <= {multiplicand[WIDTH-1], multiplicand};
            acc_reg   <= '0;
            q_reg     <= multiplier;
            q_m1_reg  <= 1'b0;
            count_reg <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          q_reg     <= q_next;
          q_m1_reg  <= q_m1_next;
          count_reg <= count_reg + CW'(1);
          if (count_reg == CW'(WIDTH - 1)) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          product_reg <= {acc_reg[WIDTH-1:0], q_reg};
          done_reg    <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign product = product_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: directed vector table, timing and
// reset corner cases, and a back-to-back random run against a signed golden product.
module tb_booth_seq_multiplier;

  localparam int W = 32;
  localparam int LAT = W + 2;  // negedges from driving start to seeing done

  logic              clk;
  logic              rst;
  logic              start;
  logic [W-1:0]      multiplicand;
  logic [W-1:0]      multiplier;
  logic [2*W-1:0]    product;
  logic              done;

  int n_cmp;
  int n_bad;
  int done_count;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] exp_v;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[11];

  booth_seq_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] golden(logic [W-1:0] a, logic [W-1:0] b);
    longint sa;
    longint sb_v;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    return sa * sb_v;
  endfunction

  task automatic check(string name, logic [2*W-1:0] act, logic [2*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 200);
    if (done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_done: got done pulse with product %h, required none", product);
      end else begin
        exp_v = sb.pop_front();
        check("product", product, exp_v);
        $display("op done: product=%h", product);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int dc0;
    logic [2*W-1:0] prev;
    logic [W-1:0] a;
    logic [W-1:0] b;

    n_cmp = 0;
    n_bad = 0;
    done_count = 0;

    vecs[0]  = '{32'd5,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[1]  = '{32'd4,          32'd7,         64'd28};
    vecs[2]  = '{32'hFFFF_FFFA,  32'hFFFF_FFFC, 64'd24};
    vecs[3]  = '{32'hFFFF_FFF8,  32'd5,         64'hFFFF_FFFF_FFFF_FFD8};
    vecs[4]  = '{32'd123,        32'd0,         64'd0};
    vecs[5]  = '{32'd456,        32'd1,         64'd456};
    vecs[6]  = '{32'd65536,      32'd65536,     64'h0000_0001_0000_0000};
    vecs[7]  = '{32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[8]  = '{32'h8000_0000,  32'd1,         64'hFFFF_FFFF_8000_0000};
    vecs[9]  = '{32'd1,          32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[10] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};

    // Reset state
    rst = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(negedge clk);
    check("reset_product", product, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_product", product, 64'd0);
    check("post_reset_done", {63'd0, done}, 64'd0);
    $display("reset: product=%h done=%b", product, done);

    // Mid-RUN reset aborts with no done pulse
    multiplicand = 32'd5;
    multiplier = 32'hFFFF_FFFD;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #2 check("midrun_reset_product", product, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrun_reset_done_count", 64'(done_count), 64'd0);
    check("midrun_reset_product_after", product, 64'd0);
    $display("mid-run reset: done_count=%0d product=%h", done_count, product);

    // Directed vector table with latency, pulse width and hold checks
    prev = '0;
    foreach (vecs[i]) begin
      multiplicand = vecs[i].a;
      multiplier = vecs[i].b;
      start = 1'b1;
      sb.push_back(vecs[i].p);
      @(negedge clk);
      start = 1'b0;
      multiplicand = ~vecs[i].a;
      multiplier = ~vecs[i].b;
      check("product_hold_in_run", product, prev);
      wait_done(c);
      check("latency", 64'(c + 1), 64'(LAT));
      @(negedge clk);
      check("done_width", {63'd0, done}, 64'd0);
      prev = vecs[i].p;
    end

    // Second start during RUN is ignored and not queued
    dc0 = done_count;
    multiplicand = 32'd3;
    multiplier = 32'hFFFF_FFF7;
    start = 1'b1;
    sb.push_back(64'hFFFF_FFFF_FFFF_FFE5);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    multiplicand = 32'd100;
    multiplier = 32'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    check("ignored_start_latency", 64'(c + 7), 64'(LAT));
    repeat (40) @(negedge clk);
    check("ignored_start_done_count", 64'(done_count - dc0), 64'd1);
    check("ignored_start_product_hold", product, 64'hFFFF_FFFF_FFFF_FFE5);

    // Random back-to-back operations with start held high
    dc0 = done_count;
    a = $urandom;
    b = $urandom;
    multiplicand = a;
    multiplier = b;
    sb.push_back(golden(a, b));
    start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      wait_done(c);
      check("b2b_latency", 64'(c), 64'(LAT));
      if (i < 999) begin
        a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        b = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        multiplicand = a;
        multiplier = b;
        sb.push_back(golden(a, b));
      end else begin
        start = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
    check("random_done_count", 64'(done_count - dc0), 64'd1000);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
